// File: rtl/sprite_rom_fetch.sv
// Purpose: sprite ROM responder; turns sprite word addresses into SDRAM reads and holds the last word.
// Latency: request 2 clk after an address change; data on spr_rom_dout 1 clk after sdr_rdy.
// Backpressure: sdr_req held with a stable sdr_addr until sdr_rdy; a read is never aborted.
//
// Ports: clk/nRES (async active-low reset), load_en (ROM download: invalidate, no new reads),
//        spr_rom_addr/spr_rom_dout (sprite side), busy (read outstanding),
//        sdr_req/sdr_addr/sdr_rdy/sdr_dout (SDRAM arbiter read channel), miss_cnt (saturating demand reads).
// Optional feature: define SPR_FETCH_PREFETCH_EN to add a one-word next-address prefetch buffer.
module sprite_rom_fetch #(
    parameter logic [25:0] BASE_ADDR = 26'h0200000,
    parameter int          AW        = 19
) (
    input  logic          clk,
    input  logic          nRES,
    input  logic          load_en,
    input  logic [AW-1:0] spr_rom_addr,
    output logic [31:0]   spr_rom_dout,
    output logic          busy,
    output logic          sdr_req,
    output logic [25:0]   sdr_addr,
    input  logic          sdr_rdy,
    input  logic [31:0]   sdr_dout,
    output logic [15:0]   miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DREQ = 2'd1,
        ST_PREQ = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic          cur_valid_q, cur_valid_d;
    logic [31:0]   dout_q, dout_d;
    logic          req_q, req_d;
    logic [25:0]   sdr_addr_q, sdr_addr_d;
    logic          busy_q, busy_d;
    logic [15:0]   miss_q, miss_d;
    logic [AW-1:0] req_word_q, req_word_d;   // word address of the read in flight
    logic          disc_q, disc_d;           // in-flight read overlapped a download: drop its data
    logic          demand_miss;

`ifdef SPR_FETCH_PREFETCH_EN
    logic [AW-1:0] pf_addr_q, pf_addr_d;
    logic [31:0]   pf_data_q, pf_data_d;
    logic          pf_valid_q, pf_valid_d;
    logic          pf_want_q, pf_want_d;     // a demand fill or buffer hit just landed: fetch the next word
    logic [AW-1:0] next_addr;
    logic          pf_hit;

    assign next_addr = cur_addr_q + AW'(1);
    assign pf_hit    = pf_valid_q && (addr_q == pf_addr_q);
`endif

    // Word address to SDRAM byte address; wraps modulo 2^26.
    function automatic logic [25:0] word_to_byte(input logic [AW-1:0] w);
        return BASE_ADDR + 26'({w, 2'b00});
    endfunction

    assign demand_miss = !cur_valid_q || (addr_q != cur_addr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = spr_rom_addr;
        cur_addr_d  = cur_addr_q;
        cur_valid_d = cur_valid_q;
        dout_d      = dout_q;
        req_d       = req_q;
        sdr_addr_d  = sdr_addr_q;
        busy_d      = busy_q;
        miss_d      = miss_q;
        req_word_d  = req_word_q;
        disc_d      = disc_q;
`ifdef SPR_FETCH_PREFETCH_EN
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        pf_want_d   = pf_want_q;
`endif

        // During a download everything cached is stale, every cycle.
        if (load_en) begin
            cur_valid_d = 1'b0;
`ifdef SPR_FETCH_PREFETCH_EN
            pf_valid_d  = 1'b0;
            pf_want_d   = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (!load_en) begin
                    if (demand_miss) begin
`ifdef SPR_FETCH_PREFETCH_EN
                        if (pf_hit) begin
                            dout_d      = pf_data_q;
                            cur_addr_d  = pf_addr_q;
                            cur_valid_d = 1'b1;
                            pf_valid_d  = 1'b0;
                            pf_want_d   = 1'b1;
                        end else begin
                            state_d    = ST_DREQ;
                            req_d      = 1'b1;
                            busy_d     = 1'b1;
                            sdr_addr_d = word_to_byte(addr_q);
                            req_word_d = addr_q;
                            disc_d     = 1'b0;
                        end
`else
                        state_d    = ST_DREQ;
                        req_d      = 1'b1;
                        busy_d     = 1'b1;
                        sdr_addr_d = word_to_byte(addr_q);
                        req_word_d = addr_q;
                        disc_d     = 1'b0;
`endif
                    end
`ifdef SPR_FETCH_PREFETCH_EN
                    else if (pf_want_q) begin
                        state_d    = ST_PREQ;
                        req_d      = 1'b1;
                        busy_d     = 1'b1;
                        sdr_addr_d = word_to_byte(next_addr);
                        req_word_d = next_addr;
                        disc_d     = 1'b0;
                        pf_want_d  = 1'b0;
                    end
`endif
                end
            end

            ST_DREQ: begin
                if (load_en) begin
                    disc_d = 1'b1;
                end
                if (sdr_rdy) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                    if (!load_en && !disc_q) begin
                        dout_d      = sdr_dout;
                        cur_addr_d  = req_word_q;
                        cur_valid_d = 1'b1;
`ifdef SPR_FETCH_PREFETCH_EN
                        pf_want_d   = 1'b1;
`endif
                    end
                end
            end

`ifdef SPR_FETCH_PREFETCH_EN
            ST_PREQ: begin
                if (load_en) begin
                    disc_d = 1'b1;
                end
                if (sdr_rdy) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    if (!load_en && !disc_q) begin
                        pf_data_d  = sdr_dout;
                        pf_addr_d  = req_word_q;
                        pf_valid_d = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            dout_q      <= '0;
            req_q       <= 1'b0;
            sdr_addr_q  <= '0;
            busy_q      <= 1'b0;
            miss_q      <= '0;
            req_word_q  <= '0;
            disc_q      <= 1'b0;
`ifdef SPR_FETCH_PREFETCH_EN
            pf_addr_q   <= '0;
            pf_data_q   <= '0;
            pf_valid_q  <= 1'b0;
            pf_want_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            dout_q      <= dout_d;
            req_q       <= req_d;
            sdr_addr_q  <= sdr_addr_d;
            busy_q      <= busy_d;
            miss_q      <= miss_d;
            req_word_q  <= req_word_d;
            disc_q      <= disc_d;
`ifdef SPR_FETCH_PREFETCH_EN
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
            pf_valid_q  <= pf_valid_d;
            pf_want_q   <= pf_want_d;
`endif
        end
    end

    assign spr_rom_dout = dout_q;
    assign busy         = busy_q;
    assign sdr_req      = req_q;
    assign sdr_addr     = sdr_addr_q;
    assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_sprite_rom_fetch.sv
// Purpose: directed self-checking bench for sprite_rom_fetch in its default (no prefetch) build.
// Latency: checks request timing (2 clk after address change) and fill timing (1 clk after sdr_rdy).
// Backpressure: the bench plays the SDRAM arbiter, choosing when to strobe sdr_rdy.
module tb_sprite_rom_fetch;

    logic        clk;
    logic        nRES;
    logic        load_en;
    logic [18:0] spr_rom_addr;
    logic [31:0] spr_rom_dout;
    logic        busy;
    logic        sdr_req;
    logic [25:0] sdr_addr;
    logic        sdr_rdy;
    logic [31:0] sdr_dout;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    sprite_rom_fetch #(
        .BASE_ADDR (26'h2000000),
        .AW        (19)
    ) dut (
        .clk          (clk),
        .nRES         (nRES),
        .load_en      (load_en),
        .spr_rom_addr (spr_rom_addr),
        .spr_rom_dout (spr_rom_dout),
        .busy         (busy),
        .sdr_req      (sdr_req),
        .sdr_addr     (sdr_addr),
        .sdr_rdy      (sdr_rdy),
        .sdr_dout     (sdr_dout),
        .miss_cnt     (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [18:0] addr;
        int          lat;       // clocks from address drive to sdr_req high
        int          dly;       // extra clocks sdr_req is held before sdr_rdy
        logic [31:0] data;
        logic [25:0] exp_sdr;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rdy_pulse(input logic [31:0] d);
        sdr_rdy  = 1'b1;
        sdr_dout = d;
        tick();
        sdr_rdy  = 1'b0;
        sdr_dout = 32'h0;
    endtask

    initial begin
        logic [31:0] prev_dout;
        int          nreq;
        logic        prev_req;

        // First vector follows a download: load_en falling makes the next cycle a miss.
        vecs[0] = '{addr: 19'h00010, lat: 1, dly: 5, data: 32'hDEADBEEF, exp_sdr: 26'h2000040, exp_miss: 16'd1};
        vecs[1] = '{addr: 19'h7FFFF, lat: 2, dly: 0, data: 32'hCAFEF00D, exp_sdr: 26'h21FFFFC, exp_miss: 16'd2};
        vecs[2] = '{addr: 19'h00000, lat: 2, dly: 2, data: 32'h00000001, exp_sdr: 26'h2000000, exp_miss: 16'd3};
        vecs[3] = '{addr: 19'h2AAAA, lat: 2, dly: 1, data: 32'hA5A5A5A5, exp_sdr: 26'h20AAAA8, exp_miss: 16'd4};

        nRES         = 1'b0;
        load_en      = 1'b1;
        spr_rom_addr = 19'h00010;
        sdr_rdy      = 1'b0;
        sdr_dout     = 32'h0;
        tick();
        tick();
        chk("rst_req",  32'(sdr_req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dout", spr_rom_dout, 32'h0);
        chk("rst_miss", 32'(miss_cnt), 32'h0);
        chk("rst_addr", 32'(sdr_addr), 32'h0);

        nRES = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("load_no_req", 32'(sdr_req), 32'h0);
        end

        // Single demand reads from the table.
        prev_dout = 32'h0;
        for (int i = 0; i < 4; i++) begin
            spr_rom_addr = vecs[i].addr;
            load_en      = 1'b0;
            for (int k = 1; k <= vecs[i].lat; k++) begin
                tick();
                if (k < vecs[i].lat) chk("req_early", 32'(sdr_req), 32'h0);
            end
            chk("req_lat",  32'(sdr_req), 32'h1);
            chk("sdr_addr", 32'(sdr_addr), 32'(vecs[i].exp_sdr));
            chk("busy_hi",  32'(busy), 32'h1);
            for (int k = 0; k < vecs[i].dly; k++) tick();
            chk("req_hold",  32'(sdr_req), 32'h1);
            chk("addr_hold", 32'(sdr_addr), 32'(vecs[i].exp_sdr));
            chk("dout_hold", spr_rom_dout, prev_dout);
            rdy_pulse(vecs[i].data);
            chk("fill_dout", spr_rom_dout, vecs[i].data);
            chk("fill_req",  32'(sdr_req), 32'h0);
            chk("fill_busy", 32'(busy), 32'h0);
            chk("fill_miss", 32'(miss_cnt), 32'(vecs[i].exp_miss));
            prev_dout = vecs[i].data;
        end

        // Address change while a read is in flight.
        spr_rom_addr = 19'h00010;
        tick();
        tick();
        chk("chg_req1",  32'(sdr_req), 32'h1);
        chk("chg_addr1", 32'(sdr_addr), 32'h2000040);
        spr_rom_addr = 19'h00011;
        tick();
        chk("chg_addr_hold", 32'(sdr_addr), 32'h2000040);
        rdy_pulse(32'h11110010);
        chk("chg_dout1", spr_rom_dout, 32'h11110010);
        chk("chg_gap",   32'(sdr_req), 32'h0);
        chk("chg_miss1", 32'(miss_cnt), 32'd5);
        tick();
        chk("chg_req2",  32'(sdr_req), 32'h1);
        chk("chg_addr2", 32'(sdr_addr), 32'h2000044);
        rdy_pulse(32'h11110011);
        chk("chg_dout2", spr_rom_dout, 32'h11110011);
        chk("chg_miss2", 32'(miss_cnt), 32'd6);

        // Download starts with a read in flight: data dropped, no new reads until it ends.
        spr_rom_addr = 19'h00020;
        tick();
        tick();
        chk("ld_req",  32'(sdr_req), 32'h1);
        chk("ld_addr", 32'(sdr_addr), 32'h2000080);
        load_en = 1'b1;
        tick();
        rdy_pulse(32'h12345678);
        chk("ld_dout", spr_rom_dout, 32'h11110011);
        chk("ld_busy", 32'(busy), 32'h0);
        chk("ld_miss", 32'(miss_cnt), 32'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ld_no_req", 32'(sdr_req), 32'h0);
        end
        load_en = 1'b0;
        tick();
        chk("ld_reread",      32'(sdr_req), 32'h1);
        chk("ld_reread_addr", 32'(sdr_addr), 32'h2000080);
        rdy_pulse(32'h20202020);
        chk("ld_fill_dout", spr_rom_dout, 32'h20202020);
        chk("ld_fill_miss", 32'(miss_cnt), 32'd8);

        // New address then 200 stable clocks: exactly one SDRAM read.
        spr_rom_addr = 19'h00030;
        nreq         = 0;
        prev_req     = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            sdr_rdy  = 1'b0;
            sdr_dout = 32'h0;
            if (sdr_req && !prev_req) nreq++;
            prev_req = sdr_req;
            if (sdr_req) begin
                sdr_rdy  = 1'b1;
                sdr_dout = 32'h30303030;
            end
        end
        sdr_rdy = 1'b0;
        chk("stable_reads", 32'(nreq), 32'd1);
        chk("stable_dout",  spr_rom_dout, 32'h30303030);
        chk("stable_miss",  32'(miss_cnt), 32'd9);

        // Stray sdr_rdy in IDLE is ignored.
        rdy_pulse(32'hBADBAD00);
        chk("stray_dout", spr_rom_dout, 32'h30303030);
        chk("stray_miss", 32'(miss_cnt), 32'd9);
        tick();
        chk("stray_req", 32'(sdr_req), 32'h0);

        // Asynchronous reset in the middle of a read.
        spr_rom_addr = 19'h00040;
        tick();
        tick();
        chk("pre_rst_req", 32'(sdr_req), 32'h1);
        #2;
        nRES = 1'b0;
        #1;
        chk("arst_req",  32'(sdr_req), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_dout", spr_rom_dout, 32'h0);
        chk("arst_miss", 32'(miss_cnt), 32'h0);
        chk("arst_addr", 32'(sdr_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
